ticket_change_engine: RTL and testbench

TICKET_CHANGE_ENGINE -- requirements
Module: ticket_change_engine

---
 rtl/ticket_change_engine.sv | 179 +++++++++++++++++
 tb/tb_ticket_change_engine.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ticket_change_engine.sv
// Ticket vending controller: validates a purchase and issues tickets through a printer handshake.
// It then pays change, or refunds, through a greedy coin-dispenser handshake.
module ticket_change_engine #(
  parameter int VAL_W     = 8,
  parameter int QTY_W     = 2,
  parameter int DEST_W    = 2,
  parameter int NUM_DEST  = 3,
  parameter int DENOM_HI  = 5,
  parameter int DENOM_MID = 2,
  parameter int DENOM_LO  = 1
) (
  input  logic                   CLK,
  input  logic                   RD,
  input  logic                   FINISH,
  input  logic                   CANCEL,
  input  logic [DEST_W-1:0]      DESTINATION_IN,
  input  logic [QTY_W-1:0]       QUA_IN,
  input  logic [VAL_W-1:0]       COST_IN,
  input  logic [VAL_W-1:0]       COIN_IN,
  output logic [(2**DEST_W)-1:0] TICKET,
  output logic                   TICKET_VALID,
  input  logic                   TICKET_ACK,
  output logic [2:0]             COIN_SEL,
  output logic                   COIN_VALID,
  input  logic                   COIN_ACK,
  output logic [VAL_W-1:0]       REST,
  output logic                   ACT_1,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int unsigned TKT_W = 2**DEST_W;
  localparam int unsigned TOT_W = VAL_W + QTY_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_CHANGE, S_REFUND, S_DONE
  } state_t;

  state_t              state;
  logic [DEST_W-1:0]   dest_q;
  logic [QTY_W-1:0]    qty_q;
  logic [QTY_W-1:0]    cnt;
  logic [VAL_W-1:0]    cost_q;
  logic [VAL_W-1:0]    coin_q;
  logic [TOT_W-1:0]    total;
  logic                reject;
  logic [VAL_W-1:0]    rest_after;
  logic [TKT_W-1:0]    ticket_onehot;

  function automatic logic [2:0] pick_coin(input logic [VAL_W-1:0] amt);
    if (amt >= VAL_W'(DENOM_HI))       return 3'b100;
    else if (amt >= VAL_W'(DENOM_MID)) return 3'b010;
    else if (amt != '0)                return 3'b001;
    else                               return 3'b000;
  endfunction

  function automatic logic [VAL_W-1:0] coin_value(input logic [2:0] sel);
    case (sel)
      3'b100:  return VAL_W'(DENOM_HI);
      3'b010:  return VAL_W'(DENOM_MID);
      3'b001:  return VAL_W'(DENOM_LO);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    total         = TOT_W'(cost_q) * TOT_W'(qty_q);
    reject        = (qty_q == '0) ||
                    ((DEST_W+1)'(dest_q) >= (DEST_W+1)'(NUM_DEST)) ||
                    (total > TOT_W'(coin_q));
    rest_after    = REST - coin_value(COIN_SEL);
    ticket_onehot = TKT_W'(1) << dest_q;
  end

  always_ff @(posedge CLK) begin
    if (!RD) begin
      state        <= S_IDLE;
      dest_q       <= '0;
      qty_q        <= '0;
      cost_q       <= '0;
      coin_q       <= '0;
      cnt          <= '0;
      REST         <= '0;
      TICKET       <= '0;
      TICKET_VALID <= 1'b0;
      COIN_SEL     <= '0;
      COIN_VALID   <= 1'b0;
      ACT_1        <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (FINISH) begin
            dest_q <= DESTINATION_IN;
            qty_q  <= QUA_IN;
            cost_q <= COST_IN;
            coin_q <= COIN_IN;
            ACT_1  <= 1'b0;
            BUSY   <= 1'b1;
            state  <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (reject) begin
            REST       <= coin_q;
            ACT_1      <= 1'b0;
            COIN_VALID <= (coin_q != '0);
            COIN_SEL   <= pick_coin(coin_q);
            state      <= S_REFUND;
          end else begin
            REST         <= coin_q - total[VAL_W-1:0];
            ACT_1        <= 1'b1;
            cnt          <= qty_q;
            TICKET_VALID <= 1'b1;
            TICKET       <= ticket_onehot;
            state        <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // An ACK outranks a simultaneous CANCEL; cancel only counts before the first ACK.
          if (TICKET_ACK) begin
            cnt <= cnt - QTY_W'(1);
            if (cnt == QTY_W'(1)) begin
              TICKET_VALID <= 1'b0;
              TICKET       <= '0;
              if (REST != '0) begin
                COIN_VALID <= 1'b1;
                COIN_SEL   <= pick_coin(REST);
                state      <= S_CHANGE;
              end else begin
                DONE  <= 1'b1;
                state <= S_DONE;
              end
            end
          end else if (CANCEL && (cnt == qty_q)) begin
            REST         <= coin_q;
            ACT_1        <= 1'b0;
            TICKET_VALID <= 1'b0;
            TICKET       <= '0;
            COIN_VALID   <= (coin_q != '0);
            COIN_SEL     <= pick_coin(coin_q);
            state        <= S_REFUND;
          end
        end

        S_CHANGE, S_REFUND: begin
          if (REST == '0) begin
            COIN_VALID <= 1'b0;
            COIN_SEL   <= '0;
            DONE       <= 1'b1;
            state      <= S_DONE;
          end else if (COIN_ACK) begin
            REST <= rest_after;
            if (rest_after == '0) begin
              COIN_VALID <= 1'b0;
              COIN_SEL   <= '0;
              DONE       <= 1'b1;
              state      <= S_DONE;
            end else begin
              COIN_SEL <= pick_coin(rest_after);
            end
          end
        end

        S_DONE: begin
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_change_engine.sv
// Bench for ticket_change_engine: directed scenarios plus random purchases checked against
// a transaction-level model (accept decision, ticket count, greedy coin list).
module tb_ticket_change_engine;

  localparam int VAL_W = 8, QTY_W = 2, DEST_W = 2, NUM_DEST = 3;

  logic                   clk = 1'b0;
  logic                   rd;
  logic                   finish, cancel, ticket_ack, coin_ack;
  logic [DEST_W-1:0]      dest_in;
  logic [QTY_W-1:0]       qty_in;
  logic [VAL_W-1:0]       cost_in, coin_in;
  logic [(2**DEST_W)-1:0] ticket;
  logic                   ticket_valid, coin_valid;
  logic [2:0]             coin_sel;
  logic [VAL_W-1:0]       rest;
  logic                   act_1, busy, done;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_coins[$];

  ticket_change_engine #(
    .VAL_W(VAL_W), .QTY_W(QTY_W), .DEST_W(DEST_W), .NUM_DEST(NUM_DEST),
    .DENOM_HI(5), .DENOM_MID(2), .DENOM_LO(1)
  ) dut (
    .CLK(clk), .RD(rd), .FINISH(finish), .CANCEL(cancel),
    .DESTINATION_IN(dest_in), .QUA_IN(qty_in), .COST_IN(cost_in), .COIN_IN(coin_in),
    .TICKET(ticket), .TICKET_VALID(ticket_valid), .TICKET_ACK(ticket_ack),
    .COIN_SEL(coin_sel), .COIN_VALID(coin_valid), .COIN_ACK(coin_ack),
    .REST(rest), .ACT_1(act_1), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void make_coins(input int amt);
    exp_coins.delete();
    while (amt > 0) begin
      if (amt >= 5)      begin exp_coins.push_back(5); amt -= 5; end
      else if (amt >= 2) begin exp_coins.push_back(2); amt -= 2; end
      else               begin exp_coins.push_back(1); amt -= 1; end
    end
  endfunction

  function automatic int sel_value(input logic [2:0] s);
    case (s)
      3'b100:  return 5;
      3'b010:  return 2;
      3'b001:  return 1;
      default: return -1;
    endcase
  endfunction

  // mode 0: no cancel before first ACK; 1: cancel at first ticket offer; 2: cancel with every ACK
  task automatic run_txn(input int d, input int q, input int c, input int m,
                         input int mode, input int w_lo, input int w_hi);
    int  total, cur_rest, tickets, waited, w, cyc, exp_tickets;
    bit  accept, cancelled, cancel_sent, finished;
    total     = c * q;
    accept    = (q != 0) && (d < NUM_DEST) && (total <= m);
    cancelled = (mode == 1) && accept;
    exp_tickets = (accept && !cancelled) ? q : 0;
    cur_rest  = accept ? m - total : m;
    make_coins(cancelled ? m : cur_rest);

    @(negedge clk);
    dest_in = DEST_W'(d); qty_in = QTY_W'(q); cost_in = VAL_W'(c); coin_in = VAL_W'(m);
    finish  = 1'b1;
    @(negedge clk);
    finish  = 1'b0;
    dest_in = DEST_W'($urandom); qty_in = QTY_W'($urandom);
    cost_in = VAL_W'($urandom);  coin_in = VAL_W'($urandom);
    chk("busy_check", busy, 1);
    @(negedge clk);
    chk("act_after_check", act_1, accept);
    chk("rest_after_check", rest, cur_rest);
    chk("tv_after_check", ticket_valid, accept);

    tickets = 0; waited = 0; cancel_sent = 0; finished = 0;
    w = $urandom_range(w_hi, w_lo);
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (done) begin finished = 1; break; end
      chk("one_valid", ticket_valid && coin_valid, 0);
      if (ticket_valid) begin
        chk("ticket_onehot", ticket, 32'(1) << d);
        if (cancel_sent) begin
          chk("tv_after_cancel", ticket_valid, 0);
        end else if (cancelled) begin
          cancel = 1'b1; cancel_sent = 1; cur_rest = m;
        end else if (waited >= w) begin
          ticket_ack = 1'b1; cancel = (mode == 2) || (tickets > 0 && $urandom_range(1, 0) == 1);
          tickets++; waited = 0; w = $urandom_range(w_hi, w_lo);
        end else begin
          waited++;
          if (tickets > 0 || mode == 2) cancel = ($urandom_range(1, 0) == 1) && tickets > 0;
        end
      end else if (coin_valid) begin
        chk("rest_running", rest, cur_rest);
        cancel = ($urandom_range(1, 0) == 1);
        if (exp_coins.size() == 0) chk("extra_coin", sel_value(coin_sel), 0);
        else begin
          chk("coin_sel", sel_value(coin_sel), exp_coins[0]);
          if (waited >= w) begin
            coin_ack = 1'b1; cur_rest -= exp_coins[0];
            void'(exp_coins.pop_front()); waited = 0; w = $urandom_range(w_hi, w_lo);
          end else waited++;
        end
      end
      @(negedge clk);
      ticket_ack = 1'b0; coin_ack = 1'b0; cancel = 1'b0;
    end
    chk("done_seen", finished, 1);
    chk("ticket_count", tickets, exp_tickets);
    chk("coins_left", exp_coins.size(), 0);
    chk("rest_final", rest, 0);
    chk("act_final", act_1, accept && !cancelled);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("act_retained", act_1, accept && !cancelled);
  endtask

  initial begin
    rd = 1'b0; finish = 1'b0; cancel = 1'b0; ticket_ack = 1'b0; coin_ack = 1'b0;
    dest_in = '0; qty_in = '0; cost_in = '0; coin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_tv", ticket_valid, 0);  chk("rst_cv", coin_valid, 0);
    chk("rst_rest", rest, 0);        chk("rst_busy", busy, 0);
    chk("rst_act", act_1, 0);        chk("rst_done", done, 0);
    rd = 1'b1;

    run_txn(1, 2, 3, 10, 0, 0, 0);   // sale, change MID MID
    run_txn(0, 3, 4, 10, 0, 0, 1);   // too expensive, refund HI HI
    run_txn(2, 2, 2, 9, 1, 0, 0);    // cancel before ACK, refund HI MID MID
    run_txn(1, 2, 3, 10, 2, 3, 3);   // slow ACK, cancel with ACK ignored
    run_txn(0, 0, 3, 7, 0, 0, 0);    // qty 0 refund
    run_txn(3, 1, 1, 7, 0, 0, 0);    // invalid dest refund
    run_txn(3, 1, 1, 0, 0, 0, 0);    // refund of nothing
    run_txn(2, 3, 3, 9, 0, 1, 2);    // exact payment, no change

    // reset during CHANGE with REST=3
    @(negedge clk);
    dest_in = 2'd0; qty_in = 2'd1; cost_in = 8'd2; coin_in = 8'd5; finish = 1'b1;
    @(negedge clk); finish = 1'b0;
    @(negedge clk); chk("rst_mid_tv", ticket_valid, 1);
    ticket_ack = 1'b1;
    @(negedge clk); ticket_ack = 1'b0;
    chk("rst_mid_rest", rest, 3);
    chk("rst_mid_sel", coin_sel, 3'b010);
    rd = 1'b0; coin_ack = 1'b1; finish = 1'b1; cancel = 1'b1;
    @(negedge clk);
    rd = 1'b1; coin_ack = 1'b0; finish = 1'b0; cancel = 1'b0;
    chk("rst2_rest", rest, 0);   chk("rst2_cv", coin_valid, 0);
    chk("rst2_sel", coin_sel, 0); chk("rst2_tv", ticket_valid, 0);
    chk("rst2_ticket", ticket, 0); chk("rst2_act", act_1, 0);
    chk("rst2_busy", busy, 0);   chk("rst2_done", done, 0);
    @(negedge clk);
    chk("rst2_still_idle", busy, 0);
    run_txn(1, 1, 4, 12, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(80, 0),
              $urandom_range(255, 0), $urandom_range(2, 0), 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
